// File: rtl/button_conditioner.sv
// Push-button front end: 2-flop synchroniser, per-button debounce FSM, clean level plus 1-cycle press/release pulses.
// Latency DEBOUNCE_LIMIT+2 clocks from raw edge to outputs; no backpressure. Define BUTTON_AUTOREPEAT_EN for held-button repeat presses.
module button_conditioner #(
    parameter int NB_BUTTON      = 4,
    parameter int NB_DEBOUNCE    = 20,
    parameter int DEBOUNCE_LIMIT = 1000000,
    parameter int REPEAT_DELAY   = 50000000,
    parameter int REPEAT_PERIOD  = 10000000
) (
    input  logic                 clock,
    input  logic                 i_reset,
    input  logic [NB_BUTTON-1:0] i_button,
    output logic [NB_BUTTON-1:0] o_level,
    output logic [NB_BUTTON-1:0] o_press,
    output logic [NB_BUTTON-1:0] o_release
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_HIGH = 2'd1,
        PRESSED   = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    localparam logic [NB_DEBOUNCE-1:0] CNT_ONE  = NB_DEBOUNCE'(1);
    localparam logic [NB_DEBOUNCE-1:0] CNT_LAST = NB_DEBOUNCE'(DEBOUNCE_LIMIT - 1);
`ifdef BUTTON_AUTOREPEAT_EN
    // Reloading to DELAY-PERIOD makes every later repeat hit the same compare value.
    localparam logic [NB_DEBOUNCE-1:0] HOLD_FIRE  = NB_DEBOUNCE'(REPEAT_DELAY - 1);
    localparam logic [NB_DEBOUNCE-1:0] HOLD_REARM = NB_DEBOUNCE'(REPEAT_DELAY - REPEAT_PERIOD);
`endif

    if (DEBOUNCE_LIMIT < 2) begin : g_bad_limit
        $error("button_conditioner: DEBOUNCE_LIMIT must be at least 2");
    end

    logic [NB_BUTTON-1:0] sync_a;
    logic [NB_BUTTON-1:0] sync_b;

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= i_button;
            sync_b <= sync_a;
        end
    end

    for (genvar gi = 0; gi < NB_BUTTON; gi++) begin : g_btn
        state_t                 state;
        logic [NB_DEBOUNCE-1:0] cnt;
        logic                   level_q;
        logic                   press_q;
        logic                   release_q;
        logic                   s_btn;
`ifdef BUTTON_AUTOREPEAT_EN
        logic [NB_DEBOUNCE-1:0] hold;
`endif

        assign s_btn = sync_b[gi];

        always_ff @(posedge clock or negedge i_reset) begin
            if (!i_reset) begin
                state     <= IDLE;
                cnt       <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
                hold      <= '0;
`endif
            end else begin
                press_q   <= 1'b0;
                release_q <= 1'b0;
                case (state)
                    IDLE: begin
                        if (s_btn) begin
                            state <= WAIT_HIGH;
                            cnt   <= CNT_ONE;
                        end
                    end
                    WAIT_HIGH: begin
                        if (!s_btn) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else if (cnt == CNT_LAST) begin
                            state   <= PRESSED;
                            cnt     <= '0;
                            level_q <= 1'b1;
                            press_q <= 1'b1;
`ifdef BUTTON_AUTOREPEAT_EN
                            hold    <= '0;
`endif
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    PRESSED: begin
                        if (!s_btn) begin
                            state <= WAIT_LOW;
                            cnt   <= CNT_ONE;
`ifdef BUTTON_AUTOREPEAT_EN
                            hold  <= '0;
                        end else if (hold == HOLD_FIRE) begin
                            press_q <= 1'b1;
                            hold    <= HOLD_REARM;
                        end else begin
                            hold <= hold + CNT_ONE;
`endif
                        end
                    end
                    WAIT_LOW: begin
                        if (s_btn) begin
                            // Bounce during release: level stays high and no new press is issued.
                            state <= PRESSED;
                            cnt   <= '0;
`ifdef BUTTON_AUTOREPEAT_EN
                            hold  <= '0;
`endif
                        end else if (cnt == CNT_LAST) begin
                            state     <= IDLE;
                            cnt       <= '0;
                            level_q   <= 1'b0;
                            release_q <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end

        assign o_level[gi]   = level_q;
        assign o_press[gi]   = press_q;
        assign o_release[gi] = release_q;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: expected pulses are queued when stimulus is applied and matched as pulses appear.
module tb_button_conditioner;

    localparam int NB  = 4;
    localparam int LAT = 10;

    logic          clock = 1'b0;
    logic          i_reset;
    logic [NB-1:0] i_button;
    logic [NB-1:0] o_level;
    logic [NB-1:0] o_press;
    logic [NB-1:0] o_release;

    button_conditioner #(
        .NB_BUTTON     (NB),
        .NB_DEBOUNCE   (8),
        .DEBOUNCE_LIMIT(8),
        .REPEAT_DELAY  (20),
        .REPEAT_PERIOD (5)
    ) dut (
        .clock    (clock),
        .i_reset  (i_reset),
        .i_button (i_button),
        .o_level  (o_level),
        .o_press  (o_press),
        .o_release(o_release)
    );

    always #5 clock = ~clock;

    typedef struct {
        int            cyc;
        logic [NB-1:0] press;
        logic [NB-1:0] rel;
        logic [NB-1:0] level;
    } ev_t;

    ev_t sb[$];
    int  cyc      = 0;
    int  n_assert = 0;
    int  n_fail   = 0;

    task automatic expect_ev(input int c, input logic [NB-1:0] p, input logic [NB-1:0] r,
                             input logic [NB-1:0] l);
        ev_t e;
        e.cyc   = c;
        e.press = p;
        e.rel   = r;
        e.level = l;
        sb.push_back(e);
    endtask

    // One clock, then check overlap, missed pulses and any pulse against the queue head.
    task automatic tick();
        ev_t e;
        @(posedge clock);
        #1;
        cyc++;
        n_assert++;
        assert ((o_press & o_release) === '0) else begin
            n_fail++;
            $error("FAIL overlap cyc=%0d press=%b release=%b required no common bit", cyc, o_press, o_release);
        end
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            n_assert++;
            n_fail++;
            $error("FAIL missed_pulse at cyc=%0d: nothing seen, required press=%b release=%b", e.cyc, e.press, e.rel);
        end
        if ((o_press | o_release) !== '0) begin
            n_assert++;
            assert (sb.size() > 0) else begin
                n_fail++;
                $error("FAIL unexpected_pulse cyc=%0d press=%b release=%b, required none", cyc, o_press, o_release);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_assert++;
                assert ({cyc, o_press, o_release, o_level} === {e.cyc, e.press, e.rel, e.level}) else begin
                    n_fail++;
                    $error("FAIL pulse got cyc=%0d p=%b r=%b l=%b required cyc=%0d p=%b r=%b l=%b",
                           cyc, o_press, o_release, o_level, e.cyc, e.press, e.rel, e.level);
                end
            end
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic check_level(input string tag, input logic [NB-1:0] exp);
        n_assert++;
        assert (o_level === exp) else begin
            n_fail++;
            $error("FAIL %s o_level=%b required %b", tag, o_level, exp);
        end
    endtask

    initial begin
        int p;
        i_reset  = 1'b0;
        i_button = 4'hF;

        // Reset holds everything low even with all buttons pressed.
        for (int k = 0; k < 3; k++) begin
            tick();
            n_assert++;
            assert ({o_level, o_press, o_release} === 12'h000) else begin
                n_fail++;
                $error("FAIL reset_outputs level=%b press=%b release=%b required all 0", o_level, o_press, o_release);
            end
        end

        // Held across reset release: treated as a fresh press.
        i_reset = 1'b1;
        expect_ev(cyc + LAT, 4'hF, 4'h0, 4'hF);
        run(LAT);
        check_level("level_after_reset", 4'hF);
        i_button = 4'h0;
        expect_ev(cyc + LAT, 4'h0, 4'hF, 4'h0);
        run(LAT + 2);
        check_level("level_all_released", 4'h0);

        // Clean press and release on bit 0.
        i_button = 4'b0001;
        expect_ev(cyc + LAT, 4'b0001, 4'b0000, 4'b0001);
        run(LAT + 5);
        check_level("level_press0_held", 4'b0001);
        i_button = 4'b0000;
        expect_ev(cyc + LAT, 4'b0000, 4'b0001, 4'b0000);
        run(LAT + 2);
        check_level("level_release0", 4'b0000);

        // Bit 1 bounces every 3 clocks for 30 clocks, then settles high.
        for (int k = 0; k < 10; k++) begin
            i_button = (k % 2 == 0) ? 4'b0010 : 4'b0000;
            run(3);
        end
        check_level("level_during_bounce", 4'b0000);
        i_button = 4'b0010;
        expect_ev(cyc + LAT, 4'b0010, 4'b0000, 4'b0010);
        run(LAT + 2);
        i_button = 4'b0000;
        expect_ev(cyc + LAT, 4'b0000, 4'b0010, 4'b0000);
        run(LAT + 2);

        // Simultaneous press on bits 1 and 3.
        i_button = 4'b1010;
        expect_ev(cyc + LAT, 4'b1010, 4'b0000, 4'b1010);
        run(LAT + 1);
        i_button = 4'b0000;
        expect_ev(cyc + LAT, 4'b0000, 4'b1010, 4'b0000);
        run(LAT + 2);

        // Long hold on bit 2: repeats only when auto-repeat is built in.
        i_button = 4'b0100;
        p = cyc + LAT;
        expect_ev(p, 4'b0100, 4'b0000, 4'b0100);
`ifdef BUTTON_AUTOREPEAT_EN
        for (int k = 20; k <= 60; k += 5) expect_ev(p + k, 4'b0100, 4'b0000, 4'b0100);
`endif
        run(LAT + 40);
        check_level("level_long_hold", 4'b0100);
        run(22);
        i_button = 4'b0000;
        expect_ev(cyc + LAT, 4'b0000, 4'b0100, 4'b0000);
        run(LAT + 4);
        check_level("level_final", 4'b0000);

        n_assert++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drain %0d pulses outstanding, required 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
